// File: rtl/morse_rx_timed.sv
// Morse receiver with built-in dot/dash, inter-character and word timers.
// Optional ASCII decode of each record when MORSE_RX_ASCII_EN is defined.
`timescale 1ns/1ps
module morse_rx_timed #(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int MAX_SYMS    = 6,
  parameter int DASH_UNITS  = 2,
  parameter int INTER_UNITS = 3,
  parameter int WORD_UNITS  = 7,
  localparam int LEN_W      = $clog2(MAX_SYMS + 1)
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                user_btn,
  input  logic                char_ready,
  output logic                char_valid,
  output logic [MAX_SYMS-1:0] char_data,
  output logic [LEN_W-1:0]    char_len,
  output logic                char_err,
  output logic                char_overrun,
  output logic                word_end,
  output logic [7:0]          char_ascii
);

  // state     | meaning
  // IDLE      | no character in progress
  // PRESS     | button held, timing the element
  // GAP       | released, waiting for next element or character gap
  // WORD_WAIT | character emitted, waiting for next press or word gap

  localparam int T_DASH  = DASH_UNITS * UNIT_CYCLES;
  localparam int T_INTER = INTER_UNITS * UNIT_CYCLES;
  localparam int T_WORD  = WORD_UNITS * UNIT_CYCLES;
  localparam int CNT_W   = $clog2(T_WORD + 1);

  localparam logic [CNT_W-1:0] T_DASH_C     = CNT_W'(T_DASH);
  localparam logic [CNT_W-1:0] T_INTER_M1_C = CNT_W'(T_INTER - 1);
  localparam logic [CNT_W-1:0] T_WORD_M1_C  = CNT_W'(T_WORD - 1);
  localparam logic [CNT_W-1:0] T_WORD_C     = CNT_W'(T_WORD);
  localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(MAX_SYMS);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [MAX_SYMS-1:0] sym_q, sym_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                err_q, err_d;
  logic                emit;
  logic                word_end_d;

  // count_q holds the number of earlier samples in the current phase, so
  // the thresholds fire on the sample that completes the interval.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sym_d      = sym_q;
    len_d      = len_q;
    err_d      = err_q;
    emit       = 1'b0;
    word_end_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (user_btn) begin
          state_d = PRESS;
          count_d = CNT_W'(1);
        end
      end
      PRESS: begin
        if (user_btn) begin
          if (count_q != T_WORD_C) count_d = count_q + 1'b1;
        end else begin
          if (len_q == LEN_MAX) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < MAX_SYMS; i++)
              if (len_q == LEN_W'(i)) sym_d[i] = (count_q >= T_DASH_C);
            len_d = len_q + 1'b1;
          end
          state_d = GAP;
          count_d = CNT_W'(1);
        end
      end
      GAP: begin
        if (user_btn) begin
          state_d = PRESS;
          count_d = CNT_W'(1);
        end else begin
          count_d = count_q + 1'b1;
          if (count_q == T_INTER_M1_C) begin
            emit    = 1'b1;
            sym_d   = '0;
            len_d   = '0;
            err_d   = 1'b0;
            state_d = WORD_WAIT;
          end
        end
      end
      WORD_WAIT: begin
        if (user_btn) begin
          state_d = PRESS;
          count_d = CNT_W'(1);
        end else begin
          count_d = count_q + 1'b1;
          if (count_q == T_WORD_M1_C) begin
            word_end_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      sym_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      word_end <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sym_q    <= sym_d;
      len_q    <= len_d;
      err_q    <= err_d;
      word_end <= word_end_d;
    end
  end

  wire load = emit && (!char_valid || char_ready);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      char_valid   <= 1'b0;
      char_data    <= '0;
      char_len     <= '0;
      char_err     <= 1'b0;
      char_overrun <= 1'b0;
    end else begin
      char_overrun <= emit && !load;
      if (load) begin
        char_valid <= 1'b1;
        char_data  <= sym_q;
        char_len   <= len_q;
        char_err   <= err_q;
      end else if (char_valid && char_ready) begin
        char_valid <= 1'b0;
      end
    end
  end

`ifdef MORSE_RX_ASCII_EN
  // Key is {length, first five elements}; bit0 is the first element, 1 = dash.
  function automatic logic [7:0] morse_ascii(input logic [MAX_SYMS-1:0] d,
                                             input logic [LEN_W-1:0] n,
                                             input logic e);
    logic [7:0] d8;
    logic [7:0] key;
    logic [7:0] a;
    d8 = '0;
    d8[MAX_SYMS-1:0] = d;
    key = {3'(n), d8[4:0]};
    a = 8'h3F;
    if (!e && n != '0 && int'(n) <= 5) begin
      case (key)
        {3'd1, 5'b00000}: a = 8'h45; // E
        {3'd1, 5'b00001}: a = 8'h54; // T
        {3'd2, 5'b00010}: a = 8'h41; // A
        {3'd2, 5'b00000}: a = 8'h49; // I
        {3'd2, 5'b00011}: a = 8'h4D; // M
        {3'd2, 5'b00001}: a = 8'h4E; // N
        {3'd3, 5'b00001}: a = 8'h44; // D
        {3'd3, 5'b00011}: a = 8'h47; // G
        {3'd3, 5'b00101}: a = 8'h4B; // K
        {3'd3, 5'b00111}: a = 8'h4F; // O
        {3'd3, 5'b00010}: a = 8'h52; // R
        {3'd3, 5'b00000}: a = 8'h53; // S
        {3'd3, 5'b00100}: a = 8'h55; // U
        {3'd3, 5'b00110}: a = 8'h57; // W
        {3'd4, 5'b00001}: a = 8'h42; // B
        {3'd4, 5'b00101}: a = 8'h43; // C
        {3'd4, 5'b00100}: a = 8'h46; // F
        {3'd4, 5'b00000}: a = 8'h48; // H
        {3'd4, 5'b01110}: a = 8'h4A; // J
        {3'd4, 5'b00010}: a = 8'h4C; // L
        {3'd4, 5'b00110}: a = 8'h50; // P
        {3'd4, 5'b01011}: a = 8'h51; // Q
        {3'd4, 5'b01000}: a = 8'h56; // V
        {3'd4, 5'b01001}: a = 8'h58; // X
        {3'd4, 5'b01101}: a = 8'h59; // Y
        {3'd4, 5'b00011}: a = 8'h5A; // Z
        {3'd5, 5'b11111}: a = 8'h30;
        {3'd5, 5'b11110}: a = 8'h31;
        {3'd5, 5'b11100}: a = 8'h32;
        {3'd5, 5'b11000}: a = 8'h33;
        {3'd5, 5'b10000}: a = 8'h34;
        {3'd5, 5'b00000}: a = 8'h35;
        {3'd5, 5'b00001}: a = 8'h36;
        {3'd5, 5'b00011}: a = 8'h37;
        {3'd5, 5'b00111}: a = 8'h38;
        {3'd5, 5'b01111}: a = 8'h39;
        default:          a = 8'h3F;
      endcase
    end
    return a;
  endfunction

  always_ff @(posedge clk_100MHz) begin
    if (reset) char_ascii <= 8'h00;
    else if (load) char_ascii <= morse_ascii(sym_q, len_q, err_q);
  end
`else
  assign char_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_morse_rx_timed.sv
// Scoreboard bench for morse_rx_timed with a short unit (UNIT_CYCLES=4).
`timescale 1ns/1ps
module tb_morse_rx_timed;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       user_btn = 1'b0;
  logic       char_ready = 1'b1;
  logic       char_valid;
  logic [5:0] char_data;
  logic [2:0] char_len;
  logic       char_err;
  logic       char_overrun;
  logic       word_end;
  logic [7:0] char_ascii;

  morse_rx_timed #(.UNIT_CYCLES(4)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .user_btn    (user_btn),
    .char_ready  (char_ready),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_len    (char_len),
    .char_err    (char_err),
    .char_overrun(char_overrun),
    .word_end    (word_end),
    .char_ascii  (char_ascii)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [5:0] data;
    logic [2:0] len;
    logic       err;
    logic [7:0] ascii;
  } rec_t;

  typedef struct {
    string      name;
    int         n;
    int         hi[7];
    logic [5:0] data;
    logic [2:0] len;
    logic       err;
    logic [7:0] ascii;
  } vec_t;

  rec_t exp_q[$];
  rec_t got;
  vec_t vecs[11];
  int   n_checks = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  int   ov_cnt = 0;
  int   valid_cycles = 0;

  function automatic logic [7:0] asc(input logic [7:0] v);
`ifdef MORSE_RX_ASCII_EN
    return v;
`else
    return (v == v) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      user_btn = b;
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic push_exp(input logic [5:0] d, input logic [2:0] l, input logic e,
                          input logic [7:0] a);
    rec_t r;
    r.data = d; r.len = l; r.err = e; r.ascii = asc(a);
    exp_q.push_back(r);
  endtask

  // Elements separated by one unit low; the character closes with T_INTER low.
  task automatic send_char(input int n, input int hi[7]);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, hi[k]);
      if (k < n - 1) drive(1'b0, 4);
    end
    drive(1'b0, 12);
  endtask

  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (!reset) begin
        if (word_end) we_cnt++;
        if (char_overrun) ov_cnt++;
        if (char_valid) valid_cycles++;
        if (char_valid && char_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_record: got data %0h len %0d, nothing expected",
                     char_data, char_len);
          end else begin
            got = exp_q.pop_front();
            check("rec_data", 32'(char_data), 32'(got.data));
            check("rec_len", 32'(char_len), 32'(got.len));
            check("rec_err", 32'(char_err), 32'(got.err));
            check("rec_ascii", 32'(char_ascii), 32'(got.ascii));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0, vc0, we0, vfirst, wfirst;
    int h_c[7], h_k[7], h_a[7];

    vecs[0]  = '{"A",     2, '{4, 10, 0, 0, 0, 0, 0},   6'b000010, 3'd2, 1'b0, 8'h41};
    vecs[1]  = '{"dot7",  1, '{7, 0, 0, 0, 0, 0, 0},    6'b000000, 3'd1, 1'b0, 8'h45};
    vecs[2]  = '{"dash8", 1, '{8, 0, 0, 0, 0, 0, 0},    6'b000001, 3'd1, 1'b0, 8'h54};
    vecs[3]  = '{"K",     3, '{10, 4, 10, 0, 0, 0, 0},  6'b000101, 3'd3, 1'b0, 8'h4B};
    vecs[4]  = '{"S",     3, '{4, 4, 4, 0, 0, 0, 0},    6'b000000, 3'd3, 1'b0, 8'h53};
    vecs[5]  = '{"Q",     4, '{10, 10, 4, 10, 0, 0, 0}, 6'b001011, 3'd4, 1'b0, 8'h51};
    vecs[6]  = '{"five",  5, '{4, 4, 4, 4, 4, 0, 0},    6'b000000, 3'd5, 1'b0, 8'h35};
    vecs[7]  = '{"zero",  5, '{10, 10, 10, 10, 10, 0, 0}, 6'b011111, 3'd5, 1'b0, 8'h30};
    vecs[8]  = '{"six",   6, '{4, 4, 4, 4, 4, 4, 0},    6'b000000, 3'd6, 1'b0, 8'h3F};
    vecs[9]  = '{"ovfl",  7, '{4, 4, 4, 4, 4, 4, 4},    6'b000000, 3'd6, 1'b1, 8'h3F};
    vecs[10] = '{"clean", 1, '{4, 0, 0, 0, 0, 0, 0},    6'b000000, 3'd1, 1'b0, 8'h45};

    repeat (3) @(posedge clk_100MHz);
    #1;
    check("rst_valid", 32'(char_valid), 0);
    check("rst_data", 32'(char_data), 0);
    check("rst_len", 32'(char_len), 0);
    check("rst_err", 32'(char_err), 0);
    check("rst_overrun", 32'(char_overrun), 0);
    check("rst_word_end", 32'(word_end), 0);
    check("rst_ascii", 32'(char_ascii), 0);
    reset = 1'b0;
    drive(1'b0, 3);

    foreach (vecs[i]) begin
      push_exp(vecs[i].data, vecs[i].len, vecs[i].err, vecs[i].ascii);
      send_char(vecs[i].n, vecs[i].hi);
      drive(1'b0, 2);
      check({"deliver_", vecs[i].name}, 32'(exp_q.size()), 0);
    end
    check("no_word_end_in_table", 32'(we_cnt), 0);

    // C held with ready low; K completes and must be dropped.
    h_c = '{10, 4, 10, 4, 0, 0, 0};
    h_k = '{10, 4, 10, 0, 0, 0, 0};
    char_ready = 1'b0;
    push_exp(6'b000101, 3'd4, 1'b0, 8'h43);
    send_char(4, h_c);
    drive(1'b0, 2);
    check("hold_valid", 32'(char_valid), 1);
    ov0 = ov_cnt;
    send_char(3, h_k);
    drive(1'b0, 2);
    check("overrun_pulses", 32'(ov_cnt - ov0), 1);
    check("hold_data", 32'(char_data), 32'h05);
    check("hold_len", 32'(char_len), 4);
    char_ready = 1'b1;
    drive(1'b0, 2);
    check("release_valid", 32'(char_valid), 0);
    check("release_q", 32'(exp_q.size()), 0);

    // Reset in the middle of a press discards everything.
    drive(1'b1, 5);
    reset = 1'b1;
    @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
    vc0 = valid_cycles;
    we0 = we_cnt;
    drive(1'b0, 40);
    check("rst_mid_no_valid", 32'(valid_cycles - vc0), 0);
    check("rst_mid_no_word_end", 32'(we_cnt - we0), 0);

    // 'A' after reset, then a full word gap measured from the release.
    h_a = '{4, 10, 0, 0, 0, 0, 0};
    push_exp(6'b000010, 3'd2, 1'b0, 8'h41);
    drive(1'b1, h_a[0]);
    drive(1'b0, 4);
    drive(1'b1, h_a[1]);
    we0 = we_cnt;
    vfirst = 0;
    wfirst = 0;
    for (int c = 1; c <= 40; c++) begin
      drive(1'b0, 1);
      if (char_valid && vfirst == 0) vfirst = c + 1;
      if (word_end && wfirst == 0) wfirst = c + 1;
    end
    check("word_valid_cycle", 32'(vfirst), 13);
    check("word_end_cycle", 32'(wfirst), 29);
    check("word_end_pulses", 32'(we_cnt - we0), 1);
    check("word_q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
